cmos_capture_ctrl: RTL



---
 rtl/cmos_capture_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cmos_capture_ctrl.sv
// rtl/cmos_capture_ctrl.sv - CMOS sensor capture controller
// Packs 8-bit sensor bytes into RGB565 pixels and checks per-frame geometry.
module cmos_capture_ctrl #(
  parameter logic        CMOS_VSYNC_VALID = 1'b1,
  parameter logic [10:0] IMG_HDISP        = 11'd800,
  parameter logic [10:0] IMG_VDISP        = 11'd480,
  parameter logic [3:0]  FRAME_SKIP       = 4'd10
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        cap_en,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_WAIT_SOF, S_CAPTURE} state_t;

  state_t      state_q, state_d;
  logic        vs_s1_q, vs_s1_d, hs_s1_q, hs_s1_d;
  logic [7:0]  data_s1_q, data_s1_d;
  logic        vs_s2_q, vs_s2_d, hs_s2_q, hs_s2_d;
  logic        skip_done_q, skip_done_d;
  logic [3:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic        line_err_q, line_err_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        vs_valid, vs_valid_dly, sof_evt, eof_evt, href_rise, href_fall;
  logic        line_err_next;
  logic [10:0] line_cnt_next;

  // The delayed copy stores the raw pin level so both normalise identically out of reset.
  assign vs_valid     = CMOS_VSYNC_VALID ? vs_s1_q : ~vs_s1_q;
  assign vs_valid_dly = CMOS_VSYNC_VALID ? vs_s2_q : ~vs_s2_q;
  assign sof_evt      = vs_valid & ~vs_valid_dly;
  assign eof_evt      = ~vs_valid & vs_valid_dly;
  assign href_rise    = hs_s1_q & ~hs_s2_q;
  assign href_fall    = ~hs_s1_q & hs_s2_q;

  always_comb begin
    state_d       = state_q;
    vs_s1_d       = cmos_vsync;
    hs_s1_d       = cmos_href;
    data_s1_d     = cmos_data;
    vs_s2_d       = vs_s1_q;
    hs_s2_d       = hs_s1_q;
    skip_done_d   = skip_done_q;
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_err_d    = line_err_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    line_err_next = line_err_q;
    line_cnt_next = line_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cap_en) begin
          if (!skip_done_q && FRAME_SKIP != 4'd0) begin
            state_d = S_SKIP;
          end else begin
            state_d     = S_WAIT_SOF;
            skip_done_d = 1'b1;
          end
        end
      end
      S_SKIP: begin
        if (!cap_en) begin
          state_d    = S_IDLE;
          skip_cnt_d = 4'd0;
        end else if (eof_evt) begin
          if (skip_cnt_q == FRAME_SKIP - 4'd1) begin
            skip_done_d = 1'b1;
            skip_cnt_d  = 4'd0;
            state_d     = S_WAIT_SOF;
          end else begin
            skip_cnt_d = skip_cnt_q + 4'd1;
          end
        end
      end
      S_WAIT_SOF: begin
        if (!cap_en) begin
          state_d = S_IDLE;
        end else if (sof_evt) begin
          state_d       = S_CAPTURE;
          frame_start_d = 1'b1;
          pix_cnt_d     = 11'd0;
          line_cnt_d    = 11'd0;
          line_err_d    = 1'b0;
          phase_d       = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (href_rise) begin
          pix_cnt_d = 11'd0;
        end
        if (hs_s1_q) begin
          if (!phase_q) begin
            hi_byte_d = data_s1_q;
            phase_d   = 1'b1;
          end else begin
            pix_data_d  = {hi_byte_q, data_s1_q};
            pix_valid_d = 1'b1;
            phase_d     = 1'b0;
            if (pix_cnt_q != 11'h7FF) begin
              pix_cnt_d = pix_cnt_q + 11'd1;
            end
          end
        end else begin
          phase_d = 1'b0;
        end
        if (href_fall) begin
          if (pix_cnt_q != IMG_HDISP || phase_q) begin
            line_err_next = 1'b1;
          end
          if (line_cnt_q != 11'h7FF) begin
            line_cnt_next = line_cnt_q + 11'd1;
          end
        end
        line_err_d = line_err_next;
        line_cnt_d = line_cnt_next;
        // A line closing on the same cycle as end-of-frame still counts toward the verdict.
        if (eof_evt) begin
          frame_done_d = 1'b1;
          frame_err_d  = line_err_next || (line_cnt_next != IMG_VDISP);
          frame_cnt_d  = frame_cnt_q + 8'd1;
          line_err_d   = 1'b0;
          line_cnt_d   = 11'd0;
          pix_cnt_d    = 11'd0;
          phase_d      = 1'b0;
          state_d      = cap_en ? S_WAIT_SOF : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vs_s1_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      data_s1_q     <= 8'd0;
      vs_s2_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      skip_done_q   <= 1'b0;
      skip_cnt_q    <= 4'd0;
      phase_q       <= 1'b0;
      hi_byte_q     <= 8'd0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= 16'h0000;
      pix_cnt_q     <= 11'd0;
      line_cnt_q    <= 11'd0;
      line_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      vs_s1_q       <= vs_s1_d;
      hs_s1_q       <= hs_s1_d;
      data_s1_q     <= data_s1_d;
      vs_s2_q       <= vs_s2_d;
      hs_s2_q       <= hs_s2_d;
      skip_done_q   <= skip_done_d;
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_err_q    <= line_err_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
